vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the system clock. Produces the pixel-position counters `h_readwire`/`v_readwire` consumed by `screen_manager` and every pixel-stream stage, plus hsync/vsync, a visible-area flag and per-pixel/line/frame strobes. It is the first stage of the video path; all downstream region decoders and pixel muxes are timed from its outputs.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (50 MHz clk → 25 MHz pixel rate); legal range ≥1.
- `H_VISIBLE`, `H_FRONT`, `H_SYNC`, `H_BACK`: 640, 16, 96, 48. Horizontal timing in pixels.
- `V_VISIBLE`, `V_FRONT`, `V_SYNC`, `V_BACK`: 480, 10, 2, 33. Vertical timing in lines.
- `SYNC_POL`, 0: active sync level; 0 means active-low.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_readwire` out 10: current pixel column, 0..H_TOTAL-1.
- `v_readwire` out 10: current line, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync at `SYNC_POL` level.
- `vsync` out 1: vertical sync at `SYNC_POL` level.
- `visible` out 1: high when h < H_VISIBLE and v < V_VISIBLE.
- `pix_tick` out 1: one-clk strobe on the last clk of each pixel period.
- `line_start` out 1: one-clk strobe, first clk of the pixel period where h = 0.
- `frame_start` out 1: one-clk strobe, first clk of the pixel period where h = 0 and v = 0.

## Operation
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525). Both must be ≤ 1024; this is an elaboration-time check.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick` = (div_cnt == CLK_DIV-1). With CLK_DIV = 1, `pix_tick` is constantly 1 after reset.
- On the clk edge where `pix_tick` is high:
  - h increments.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 on that wrap, v wraps to 0.
- v changes only on an h wrap.
- `hsync` is active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), which is 656..751 by default.
- `vsync` is active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), which is 490..491 by default. `vsync` transitions align with the h = 0 pixel.
- hsync, vsync, visible, line_start and frame_start are registered. They are decoded from the next-state counter values so they change on the same edge as `h_readwire`/`v_readwire`. There is zero skew between any output and the counters.
- Reset values, asserted asynchronously:
  - div_cnt = 0, h = 0, v = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - visible = 0, line_start = 0, frame_start = 0, pix_tick = 0.
- The first clk edge after `rst_n` deasserts loads the decode of (0,0): visible = 1, line_start = 1, frame_start = 1 for that clk only. Downstream stages synchronise on this first frame_start.
- Reset mid-frame returns all outputs to reset values immediately. Counting resumes at (0,0) with no partial-line artefact beyond the truncation itself.

## Timing
- Pixel period = CLK_DIV clks.
- Line = H_TOTAL × CLK_DIV clks (1600).
- Frame = V_TOTAL × H_TOTAL × CLK_DIV clks (840 000).
- `line_start` and `frame_start` are high for exactly one clk, even when CLK_DIV > 1.
- `frame_start` implies `line_start`.
- Output latency is 0 relative to counters. Consumers register their own decode, so `screen_manager`-derived priorities lag by their own pipeline only.

## Structure
- Shared header `vga_timing.vh` holds the 640x480 default constants, the derived H_TOTAL/V_TOTAL and the sync-window bounds. The same constants are used by `screen_manager` and the pixel mux.
- One natural sub-module: `pixel_tick_div` (parameter CLK_DIV; ports clk, rst_n, pix_tick).
- Counters and sync decode live in the top.

## Test plan
- Reset, then release; sample the first edge → h = 0, v = 0, visible = 1, line_start = frame_start = 1 for one clk, hsync = vsync = 1.
- Run one line (1600 clks) → h steps 0..799 every 2 clks; hsync low for exactly 96 pixels (192 clks) starting at h = 656; v increments to 1 exactly as h wraps to 0.
- Run a full frame → vsync low only for v = 490..491 (3200 clks); frame_start recurs after exactly 840 000 clks; visible high for 640×480 pixels total.
- Check visible boundaries → 1 at (639,479); 0 at (640,0), at (0,480) and at (799,524).
- Assert rst_n low at (700,300) for 3 clks → outputs go to reset values asynchronously, within the cycle; after release, restart at (0,0) with frame_start.
- CLK_DIV = 1 and SYNC_POL = 1 → h advances every clk; hsync high for h 656..751; frame period is 420 000 clks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing defaults and small decode helpers for the video path.
package vga_timing_gen_pkg;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1024;

  // Drive pol when the window is active, the opposite level otherwise.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < (lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-rate divider: registered one-clk pix_tick on the last clk of each pixel period.
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_nxt_s;
  logic          run_r;
  logic          pix_tick_r;

  // Next divider value; held at zero on the first clk out of reset so pixel (0,0) gets a full period.
  always_comb begin
    div_nxt_s = {DW{1'b0}};
    if (!run_r) begin
      div_nxt_s = {DW{1'b0}};
    end else if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = {DW{1'b0}};
    end else begin
      div_nxt_s = div_cnt_r + DW'(1);
    end
  end

  // Divider state and registered tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      div_cnt_r  <= {DW{1'b0}};
      pix_tick_r <= 1'b0;
    end else begin
      run_r      <= 1'b1;
      div_cnt_r  <= div_nxt_s;
      pix_tick_r <= (div_nxt_s == DIV_LAST);
    end
  end

  assign pix_tick = pix_tick_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with sync, visible and strobe outputs decoded
// from next-state counters so every output moves on the same edge as the counters.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_readwire,
  output logic [CNT_W-1:0] v_readwire,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);

  if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  logic             pix_tick_s;
  logic [CNT_W-1:0] h_r, v_r;
  logic [CNT_W-1:0] h_nxt_s, v_nxt_s;
  logic             wrap_s;
  logic             first_r;
  logic             hsync_r, vsync_r, visible_r, line_start_r, frame_start_r;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick_s)
  );

  // Next-state raster position; v only moves when h wraps.
  always_comb begin
    h_nxt_s = h_r;
    v_nxt_s = v_r;
    if (pix_tick_s) begin
      if (h_r == H_LAST) begin
        h_nxt_s = {CNT_W{1'b0}};
        if (v_r == V_LAST) begin
          v_nxt_s = {CNT_W{1'b0}};
        end else begin
          v_nxt_s = v_r + CNT_W'(1);
        end
      end else begin
        h_nxt_s = h_r + CNT_W'(1);
        v_nxt_s = v_r;
      end
    end else begin
      h_nxt_s = h_r;
      v_nxt_s = v_r;
    end
  end

  assign wrap_s = pix_tick_s && (h_nxt_s == {CNT_W{1'b0}});

  // Counters and output decode; the first edge after reset announces (0,0) as a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_r       <= 1'b1;
      h_r           <= {CNT_W{1'b0}};
      v_r           <= {CNT_W{1'b0}};
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      visible_r     <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      first_r       <= 1'b0;
      h_r           <= h_nxt_s;
      v_r           <= v_nxt_s;
      hsync_r       <= sync_level(in_window(h_nxt_s, HS_START, H_SYNC), SYNC_POL);
      vsync_r       <= sync_level(in_window(v_nxt_s, VS_START, V_SYNC), SYNC_POL);
      visible_r     <= (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
      line_start_r  <= first_r || wrap_s;
      frame_start_r <= first_r || (wrap_s && (v_nxt_s == {CNT_W{1'b0}}));
    end
  end

  assign h_readwire  = h_r;
  assign v_readwire  = v_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign visible     = visible_r;
  assign pix_tick    = pix_tick_s;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a closed-form raster model feeds a scoreboard, plus directed
// line/frame measurements, visible boundaries and a mid-frame asynchronous reset.
module tb_vga_timing_gen;

  // A: CLK_DIV=2, active-low sync, shortened frame (27 lines). B: CLK_DIV=1, active-high, 7 lines.
  localparam int A_DIV = 2, A_VVIS = 20, A_VFR = 2, A_VSY = 2, A_VBK = 3;
  localparam int B_DIV = 1, B_VVIS = 4,  B_VFR = 1, B_VSY = 1, B_VBK = 1;
  localparam int A_FRAME = 800 * A_DIV * (A_VVIS + A_VFR + A_VSY + A_VBK);
  localparam int B_FRAME = 800 * B_DIV * (B_VVIS + B_VFR + B_VSY + B_VBK);

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic hs, vs, vis, tick, ls, fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_vs, a_vis, a_tick, a_ls, a_fs;
  logic b_hs, b_vs, b_vis, b_tick, b_ls, b_fs;

  int pass_cnt = 0;
  int total_cnt = 0;
  int sb_n = 0;
  obs_t q_a[$];
  obs_t q_b[$];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(A_DIV), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(A_VVIS), .V_FRONT(A_VFR), .V_SYNC(A_VSY), .V_BACK(A_VBK), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .h_readwire(a_h), .v_readwire(a_v), .hsync(a_hs),
    .vsync(a_vs), .visible(a_vis), .pix_tick(a_tick), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(B_DIV), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(B_VVIS), .V_FRONT(B_VFR), .V_SYNC(B_VSY), .V_BACK(B_VBK), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .h_readwire(b_h), .v_readwire(b_v), .hsync(b_hs),
    .vsync(b_vs), .visible(b_vis), .pix_tick(b_tick), .line_start(b_ls), .frame_start(b_fs)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected outputs n clk edges after reset release (n = 0 means in reset).
  function automatic obs_t model(input int n, input int d, input int vvis, input int vfr,
                                 input int vsy, input int vbk, input logic pol);
    obs_t o;
    int p, ph, vt;
    if (n == 0) begin
      o = '{h: 10'd0, v: 10'd0, hs: ~pol, vs: ~pol, vis: 1'b0, tick: 1'b0, ls: 1'b0, fs: 1'b0};
    end else begin
      vt     = vvis + vfr + vsy + vbk;
      p      = (n - 1) / d;
      ph     = (n - 1) % d;
      o.h    = 10'(p % 800);
      o.v    = 10'((p / 800) % vt);
      o.tick = (ph == d - 1);
      o.ls   = (ph == 0) && (o.h == 10'd0);
      o.fs   = o.ls && (o.v == 10'd0);
      o.hs   = ((o.h >= 10'd656) && (o.h < 10'd752)) ? pol : ~pol;
      o.vs   = ((int'(o.v) >= vvis + vfr) && (int'(o.v) < vvis + vfr + vsy)) ? pol : ~pol;
      o.vis  = (o.h < 10'd640) && (int'(o.v) < vvis);
    end
    return o;
  endfunction

  // Stimulus side of the scoreboard: every edge (or reset assertion) queues the expected state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_n = 0;
    else sb_n = sb_n + 1;
    q_a.push_back(model(sb_n, A_DIV, A_VVIS, A_VFR, A_VSY, A_VBK, 1'b0));
    q_b.push_back(model(sb_n, B_DIV, B_VVIS, B_VFR, B_VSY, B_VBK, 1'b1));
  end

  // Output side: compare DUT state against every queued expectation away from the active edge.
  always @(negedge clk) begin
    obs_t e;
    while (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("sb_a", 64'({a_h, a_v, a_hs, a_vs, a_vis, a_tick, a_ls, a_fs}), 64'(e));
    end
    while (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("sb_b", 64'({b_h, b_v, b_hs, b_vs, b_vis, b_tick, b_ls, b_fs}), 64'(e));
    end
  end

  initial begin
    int hs_line = 0, hs_first = -1, hs_last = -1, vs_lo = 0, vis_cnt = 0, fs_seen = 0;
    int v_step_h = -1, v_step_prev = -1, prev_h = 0;
    int b_hs_cnt = 0, b_hs_first = -1, b_fs1 = -1, b_fs2 = -1;
    int wait_n = 0;
    logic bnd_in = 1'bx, bnd_h = 1'bx, bnd_v = 1'bx, bnd_end = 1'bx;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync_a", 64'(a_hs), 64'(1'b1));
    check("rst_hsync_b", 64'(b_hs), 64'(1'b0));
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("first_h", 64'(a_h), 64'd0);
    check("first_v", 64'(a_v), 64'd0);
    check("first_vis", 64'(a_vis), 64'd1);
    check("first_ls", 64'(a_ls), 64'd1);
    check("first_fs", 64'(a_fs), 64'd1);
    check("first_sync", 64'({a_hs, a_vs}), 64'b11);
    check("first_fs_b", 64'(b_fs), 64'd1);

    for (int k = 1; k <= A_FRAME; k++) begin
      if (k <= 1600 && a_hs == 1'b0) begin
        hs_line++;
        if (hs_first < 0) hs_first = int'(a_h);
        hs_last = int'(a_h);
      end
      if (a_vs == 1'b0) vs_lo++;
      if (a_vis) vis_cnt++;
      if (a_fs) fs_seen++;
      if (v_step_h < 0 && a_v == 10'd1) begin
        v_step_h = int'(a_h);
        v_step_prev = prev_h;
      end
      prev_h = int'(a_h);
      if (a_h == 10'd639 && a_v == 10'(A_VVIS - 1)) bnd_in = a_vis;
      if (a_h == 10'd640 && a_v == 10'd0) bnd_h = a_vis;
      if (a_h == 10'd0 && a_v == 10'(A_VVIS)) bnd_v = a_vis;
      if (a_h == 10'd799 && a_v == 10'(A_VVIS + A_VFR + A_VSY + A_VBK - 1)) bnd_end = a_vis;
      if (k <= 800 && b_hs) begin
        b_hs_cnt++;
        if (b_hs_first < 0) b_hs_first = int'(b_h);
      end
      if (b_fs) begin
        if (b_fs1 < 0) b_fs1 = k;
        else if (b_fs2 < 0) b_fs2 = k;
      end
      @(negedge clk);
    end

    check("frame_recur_fs", 64'(a_fs), 64'd1);
    check("frame_recur_hv", 64'({a_h, a_v}), 64'd0);
    check("hsync_clks", 64'(hs_line), 64'd192);
    check("hsync_first_h", 64'(hs_first), 64'd656);
    check("hsync_last_h", 64'(hs_last), 64'd751);
    check("vsync_clks", 64'(vs_lo), 64'(2 * 1600));
    check("visible_clks", 64'(vis_cnt), 64'(640 * A_VVIS * A_DIV));
    check("fs_per_frame", 64'(fs_seen), 64'd1);
    check("v_step_h", 64'(v_step_h), 64'd0);
    check("v_step_prev_h", 64'(v_step_prev), 64'd799);
    check("vis_639_last", 64'(bnd_in), 64'd1);
    check("vis_640_0", 64'(bnd_h), 64'd0);
    check("vis_0_vvis", 64'(bnd_v), 64'd0);
    check("vis_799_last", 64'(bnd_end), 64'd0);
    check("b_hsync_clks", 64'(b_hs_cnt), 64'd96);
    check("b_hsync_first_h", 64'(b_hs_first), 64'd656);
    check("b_frame_period", 64'(b_fs2 - b_fs1), 64'(B_FRAME));

    while (!(a_h == 10'd700 && a_v == 10'd5) && wait_n < 20000) begin
      @(negedge clk);
      wait_n++;
    end
    check("reach_700_5", 64'({a_h, a_v}), 64'({10'd700, 10'd5}));

    #1 rst_n = 1'b0;
    #1;
    check("async_rst_hv", 64'({a_h, a_v}), 64'd0);
    check("async_rst_flags", 64'({a_hs, a_vs, a_vis, a_tick, a_ls, a_fs}), 64'b110000);
    check("async_rst_b", 64'({b_h, b_hs, b_tick}), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("restart_fs", 64'({a_ls, a_fs}), 64'b11);
    check("restart_hv", 64'({a_h, a_v}), 64'd0);
    check("restart_b_fs", 64'(b_fs), 64'd1);
    @(negedge clk);
    check("restart_fs_one_clk", 64'({a_ls, a_fs}), 64'b00);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
